// File: rtl/dot_matrix_scanner.sv
// Row-scan driver for bicolour (R/G) LED dot matrices.
// A frame is double-buffered: the content source writes a shadow buffer with a
// valid/ready handshake, and the shadow is promoted to the displayed (active)
// buffer only at a frame boundary. Brightness is latched at the same point, so
// content and brightness never change partway through a frame.
//
// Each row slot is BLANK_CYC all-off cycles followed by 2**PWM_BITS show cycles.
// During the show cycles a colour is lit while pwm_cnt < brightness.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | scan parked, display blanked (enable low or just out of reset)
//   S_BLANK | ghost-blanking gap at the start of a row slot, all rows off
//   S_SHOW  | selected row driven, columns PWM-gated by latched brightness
//
// All outputs are registered and show the state of the previous cycle, except
// that enable=0 blanks the outputs on the very next cycle.

module dot_matrix_scanner #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int PWM_BITS       = 3,
  parameter int BLANK_CYC      = 1,
  parameter int ROW_ACTIVE_LOW = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [ROWS*COLS-1:0]  frame_R,
  input  logic [ROWS*COLS-1:0]  frame_G,
  input  logic                  load_req,
  output logic                  load_ready,
  input  logic [PWM_BITS-1:0]   bright_R,
  input  logic [PWM_BITS-1:0]   bright_G,
  output logic [ROWS-1:0]       ROW,
  output logic [COLS-1:0]       R_COL,
  output logic [COLS-1:0]       G_COL,
  output logic                  frame_start
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [RW-1:0]       ROW_LAST   = RW'(ROWS - 1);
  localparam logic [BW-1:0]       BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST   = {PWM_BITS{1'b1}};
  // Idle level of the row lines; XOR with a one-hot select gives the driven pattern.
  localparam logic [ROWS-1:0]     ROW_OFF    = {ROWS{(ROW_ACTIVE_LOW != 0)}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [RW-1:0]         r_row;
  logic [RW-1:0]         w_row_nxt;
  logic [BW-1:0]         r_blank_cnt;
  logic [BW-1:0]         w_blank_nxt;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [PWM_BITS-1:0]   w_pwm_nxt;
  logic                  w_frame_edge;

  logic [ROWS*COLS-1:0]  r_act_R;
  logic [ROWS*COLS-1:0]  r_act_G;
  logic [ROWS*COLS-1:0]  r_shd_R;
  logic [ROWS*COLS-1:0]  r_shd_G;
  logic                  r_pending;
  logic                  w_pending_nxt;
  logic                  w_accept;
  logic [PWM_BITS-1:0]   r_br_R;
  logic [PWM_BITS-1:0]   r_br_G;

  logic [ROWS-1:0]       w_row_hot;
  logic [COLS-1:0]       w_row_R;
  logic [COLS-1:0]       w_row_G;

  logic                  r_load_ready;
  logic [ROWS-1:0]       r_row_o;
  logic [COLS-1:0]       r_r_col;
  logic [COLS-1:0]       r_g_col;
  logic                  r_frame_start;
  logic [ROWS-1:0]       w_row_o;
  logic [COLS-1:0]       w_r_col;
  logic [COLS-1:0]       w_g_col;
  logic                  w_frame_start;

  // Scan state and counters.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_blank_cnt <= '0;
      r_pwm_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_blank_cnt <= w_blank_nxt;
      r_pwm_cnt   <= w_pwm_nxt;
    end
  end

  // Next scan state; flags the frame edge where buffers and brightness may update.
  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_blank_nxt  = r_blank_cnt;
    w_pwm_nxt    = r_pwm_cnt;
    w_frame_edge = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_row_nxt   = '0;
      w_blank_nxt = '0;
      w_pwm_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Starting a scan counts as a frame edge so a pending frame shows at once.
          w_state_nxt  = S_BLANK;
          w_row_nxt    = '0;
          w_blank_nxt  = '0;
          w_pwm_nxt    = '0;
          w_frame_edge = 1'b1;
        end
        S_BLANK: begin
          if (r_blank_cnt == BLANK_LAST) begin
            w_state_nxt = S_SHOW;
            w_blank_nxt = '0;
          end else begin
            w_blank_nxt = r_blank_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (r_pwm_cnt == PWM_LAST) begin
            w_state_nxt = S_BLANK;
            w_pwm_nxt   = '0;
            if (r_row == ROW_LAST) begin
              w_row_nxt    = '0;
              w_frame_edge = 1'b1;
            end else begin
              w_row_nxt = r_row + 1'b1;
            end
          end else begin
            w_pwm_nxt = r_pwm_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_row_nxt   = '0;
          w_blank_nxt = '0;
          w_pwm_nxt   = '0;
        end
      endcase
    end
  end

  // Handshake: a pending frame blocks new loads until it is promoted.
  always_comb begin
    w_accept      = load_req & r_load_ready;
    w_pending_nxt = r_pending;
    if (w_frame_edge && r_pending) begin
      w_pending_nxt = 1'b0;
    end else if (w_accept) begin
      w_pending_nxt = 1'b1;
    end
  end

  // Shadow capture, promotion to active and brightness latch.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_shd_R      <= '0;
      r_shd_G      <= '0;
      r_act_R      <= '0;
      r_act_G      <= '0;
      r_br_R       <= '0;
      r_br_G       <= '0;
      r_pending    <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      if (w_accept) begin
        r_shd_R <= frame_R;
        r_shd_G <= frame_G;
      end
      if (w_frame_edge) begin
        if (r_pending) begin
          r_act_R <= r_shd_R;
          r_act_G <= r_shd_G;
        end
        r_br_R <= bright_R;
        r_br_G <= bright_G;
      end
      r_pending    <= w_pending_nxt;
      r_load_ready <= ~w_pending_nxt;
    end
  end

  // Row one-hot and the current row's slice of the active buffers.
  always_comb begin
    w_row_hot = '0;
    w_row_R   = '0;
    w_row_G   = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (r_row == RW'(r)) begin
        w_row_hot[r] = 1'b1;
        w_row_R      = r_act_R[r*COLS +: COLS];
        w_row_G      = r_act_G[r*COLS +: COLS];
      end
    end
  end

  // Pin values for the next cycle; enable low blanks immediately.
  always_comb begin
    w_row_o       = ROW_OFF;
    w_r_col       = '0;
    w_g_col       = '0;
    w_frame_start = 1'b0;
    if (enable) begin
      if (r_state == S_SHOW) begin
        w_row_o = w_row_hot ^ ROW_OFF;
        w_r_col = w_row_R & {COLS{(r_pwm_cnt < r_br_R)}};
        w_g_col = w_row_G & {COLS{(r_pwm_cnt < r_br_G)}};
      end
      if ((r_state == S_BLANK) && (r_row == '0) && (r_blank_cnt == '0)) begin
        w_frame_start = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_row_o       <= ROW_OFF;
      r_r_col       <= '0;
      r_g_col       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_row_o       <= w_row_o;
      r_r_col       <= w_r_col;
      r_g_col       <= w_g_col;
      r_frame_start <= w_frame_start;
    end
  end

  assign load_ready  = r_load_ready;
  assign ROW         = r_row_o;
  assign R_COL       = r_r_col;
  assign G_COL       = r_g_col;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Bench for dot_matrix_scanner: a default 8x8 instance and a 16x4 active-high
// instance run side by side from shared stimulus. The reference model tracks
// time since scan start and derives row/slot/pwm position arithmetically.

module tb_dot_matrix_scanner;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load_req;
  logic [63:0] frame_R;
  logic [63:0] frame_G;
  logic [2:0]  bright_R;
  logic [2:0]  bright_G;

  logic [7:0]  row0, rc0, gc0;
  logic        fs0, lr0;
  logic [15:0] row1;
  logic [3:0]  rc1, gc1;
  logic        fs1, lr1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_in = ~clk_in;

  dot_matrix_scanner u_dut0 (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable),
    .frame_R(frame_R), .frame_G(frame_G),
    .load_req(load_req), .load_ready(lr0),
    .bright_R(bright_R), .bright_G(bright_G),
    .ROW(row0), .R_COL(rc0), .G_COL(gc0), .frame_start(fs0)
  );

  dot_matrix_scanner #(
    .ROWS(16), .COLS(4), .PWM_BITS(2), .BLANK_CYC(2), .ROW_ACTIVE_LOW(0)
  ) u_dut1 (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable),
    .frame_R(frame_R), .frame_G(frame_G),
    .load_req(load_req), .load_ready(lr1),
    .bright_R(bright_R[1:0]), .bright_G(bright_G[1:0]),
    .ROW(row1), .R_COL(rc1), .G_COL(gc1), .frame_start(fs1)
  );

  // Reference model state, index 0 = default instance, 1 = 16x4 instance.
  logic [63:0] m_act_R[2], m_act_G[2], m_shd_R[2], m_shd_G[2];
  bit          m_pend[2], m_run[2];
  int          m_t[2], m_brR[2], m_brG[2];
  logic [15:0] e_row[2];
  logic [7:0]  e_r[2], e_g[2];
  bit          e_fs[2], e_lr[2];

  function automatic int p_rows(int i); return (i == 0) ? 8 : 16; endfunction
  function automatic int p_cols(int i); return (i == 0) ? 8 : 4;  endfunction
  function automatic int p_pb(int i);   return (i == 0) ? 3 : 2;  endfunction
  function automatic int p_bl(int i);   return (i == 0) ? 1 : 2;  endfunction
  function automatic int p_al(int i);   return (i == 0) ? 1 : 0;  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_reset(input int i);
    m_act_R[i] = '0; m_act_G[i] = '0; m_shd_R[i] = '0; m_shd_G[i] = '0;
    m_pend[i] = 0; m_run[i] = 0; m_t[i] = 0; m_brR[i] = 0; m_brG[i] = 0;
    e_row[i] = (p_al(i) != 0) ? 16'((1 << p_rows(i)) - 1) : 16'h0;
    e_r[i] = '0; e_g[i] = '0; e_fs[i] = 0; e_lr[i] = 1;
  endtask

  // One clock edge of the behavioural model, using the inputs the DUT samples.
  task automatic model_step(input int i);
    int rows, cols, pb, bl, slot, frame, pos, row, pwm, in_r, in_g;
    logic [15:0] mask, sel;
    logic [63:0] bits_r, bits_g, cmask;
    bit old_pend, edge_now;
    if (!rst_n) begin
      model_reset(i);
      return;
    end
    rows = p_rows(i); cols = p_cols(i); pb = p_pb(i); bl = p_bl(i);
    slot  = bl + (1 << pb);
    frame = rows * slot;
    mask  = 16'((1 << rows) - 1);
    cmask = (64'd1 << cols) - 64'd1;
    e_row[i] = (p_al(i) != 0) ? mask : 16'h0;
    e_r[i] = '0; e_g[i] = '0; e_fs[i] = 0;
    if (enable && m_run[i]) begin
      pos = m_t[i] % slot;
      row = (m_t[i] / slot) % rows;
      if (pos < bl) begin
        e_fs[i] = (row == 0) && (pos == 0);
      end else begin
        pwm = pos - bl;
        sel = 16'(1 << row);
        e_row[i] = (p_al(i) != 0) ? (mask & ~sel) : sel;
        bits_r = (m_act_R[i] >> (row * cols)) & cmask;
        bits_g = (m_act_G[i] >> (row * cols)) & cmask;
        e_r[i] = (pwm < m_brR[i]) ? bits_r[7:0] : 8'h0;
        e_g[i] = (pwm < m_brG[i]) ? bits_g[7:0] : 8'h0;
      end
    end
    in_r = (i == 0) ? int'(bright_R) : int'(bright_R[1:0]);
    in_g = (i == 0) ? int'(bright_G) : int'(bright_G[1:0]);
    old_pend = m_pend[i];
    edge_now = enable && (!m_run[i] || (m_t[i] == frame - 1));
    if (edge_now) begin
      if (old_pend) begin
        m_act_R[i] = m_shd_R[i];
        m_act_G[i] = m_shd_G[i];
        m_pend[i]  = 0;
      end
      m_brR[i] = in_r;
      m_brG[i] = in_g;
    end
    if (load_req && !old_pend) begin
      m_shd_R[i] = frame_R;
      m_shd_G[i] = frame_G;
      m_pend[i]  = 1;
    end
    e_lr[i] = !m_pend[i];
    if (!enable) begin
      m_run[i] = 0; m_t[i] = 0;
    end else if (!m_run[i]) begin
      m_run[i] = 1; m_t[i] = 0;
    end else begin
      m_t[i] = (m_t[i] + 1) % frame;
    end
  endtask

  task automatic check_all();
    chk("d0_row", row0, e_row[0]);
    chk("d0_rcol", rc0, e_r[0]);
    chk("d0_gcol", gc0, e_g[0]);
    chk("d0_fstart", fs0, e_fs[0]);
    chk("d0_ready", lr0, e_lr[0]);
    chk("d1_row", row1, e_row[1]);
    chk("d1_rcol", rc1, e_r[1]);
    chk("d1_gcol", gc1, e_g[1]);
    chk("d1_fstart", fs1, e_fs[1]);
    chk("d1_ready", lr1, e_lr[1]);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in);
      model_step(0);
      model_step(1);
      @(negedge clk_in);
      check_all();
    end
  endtask

  task automatic rand_inputs();
    if (enable && ($urandom % 400 == 0)) enable = 1'b0;
    else if (!enable && ($urandom % 3 == 0)) enable = 1'b1;
    load_req = ($urandom % 6 == 0);
    if (load_req) begin
      frame_R = {$urandom, $urandom};
      frame_G = {$urandom, $urandom};
    end
    if ($urandom % 40 == 0) begin
      bright_R = 3'($urandom);
      bright_G = 3'($urandom);
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; enable = 1'b0; load_req = 1'b0;
    frame_R = '0; frame_G = '0; bright_R = '0; bright_G = '0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk_in);
    check_all();
    rst_n = 1'b1;

    // Single lit bottom row, red at 7/8 duty.
    frame_R = 64'h0000_0000_0000_00FF; frame_G = '0;
    bright_R = 3'd7; bright_G = 3'd0;
    load_req = 1'b1;
    step(1);
    load_req = 1'b0;
    enable = 1'b1;
    step(160);

    // All-ones frame, red 3/8, green off.
    frame_R = '1; frame_G = '1;
    bright_R = 3'd3; bright_G = 3'd0;
    load_req = 1'b1;
    step(1);
    load_req = 1'b0;
    step(200);

    // Drop enable while the default instance shows row 4.
    guard = 0;
    while (!(m_run[0] && m_t[0] == 40) && guard < 200) begin
      step(1);
      guard++;
    end
    if (guard >= 200) chk("wait_row4_timeout", 64'd0, 64'd1);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    step(100);

    // Randomised loads, brightness changes and enable drops.
    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      step(1);
    end

    // Asynchronous reset mid-frame while a frame is pending.
    enable = 1'b1;
    guard = 0;
    while (!(m_pend[0] && m_run[0] && m_t[0] > 20) && guard < 500) begin
      load_req = ($urandom % 2 == 0);
      frame_R = {$urandom, $urandom};
      step(1);
      guard++;
    end
    if (guard >= 500) chk("wait_pending_timeout", 64'd0, 64'd1);
    load_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_all();
    step(2);
    rst_n = 1'b1;
    bright_R = 3'd7; bright_G = 3'd7;
    step(150);

    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      step(1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
